// File: rtl/wb_arbiter2.sv
// wb_arbiter2: two-master to one-slave Wishbone classic arbiter.
// Bus cycles are granted whole (cyc-delimited) with round-robin priority.
// A watchdog turns a stalled strobe into an error termination.
module wb_arbiter2 #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 128,
  parameter int SEL_GRAN   = 8,
  parameter int TIMEOUT    = 64,
  localparam int SEL_WIDTH = DATA_WIDTH / SEL_GRAN
) (
  input  logic                  clk,
  input  logic                  rst,

  // master 0 (instruction fetch)
  input  logic [ADDR_WIDTH-1:0] m0_adr_i,
  input  logic [DATA_WIDTH-1:0] m0_dat_i,
  output logic [DATA_WIDTH-1:0] m0_dat_o,
  input  logic                  m0_we_i,
  input  logic [SEL_WIDTH-1:0]  m0_sel_i,
  input  logic                  m0_stb_i,
  input  logic                  m0_cyc_i,
  output logic                  m0_ack_o,
  output logic                  m0_err_o,
  output logic                  m0_rty_o,

  // master 1 (data access)
  input  logic [ADDR_WIDTH-1:0] m1_adr_i,
  input  logic [DATA_WIDTH-1:0] m1_dat_i,
  output logic [DATA_WIDTH-1:0] m1_dat_o,
  input  logic                  m1_we_i,
  input  logic [SEL_WIDTH-1:0]  m1_sel_i,
  input  logic                  m1_stb_i,
  input  logic                  m1_cyc_i,
  output logic                  m1_ack_o,
  output logic                  m1_err_o,
  output logic                  m1_rty_o,

  // shared slave
  output logic [ADDR_WIDTH-1:0] s_adr_o,
  output logic [DATA_WIDTH-1:0] s_dat_o,
  input  logic [DATA_WIDTH-1:0] s_dat_i,
  output logic                  s_we_o,
  output logic [SEL_WIDTH-1:0]  s_sel_o,
  output logic                  s_stb_o,
  output logic                  s_cyc_o,
  input  logic                  s_ack_i,
  input  logic                  s_err_i,
  input  logic                  s_rty_i
);

  // The counter only ever needs to reach TIMEOUT-1.
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             prio_q, prio_d;
  logic             grant_end;
  logic             slave_term;
  logic [CNT_W-1:0] wd_cnt_q;
  logic             forced_q;

  assign slave_term = s_ack_i | s_err_i | s_rty_i;

  // Read data goes to both masters unconditionally; only ack qualifies it.
  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;

  // Arbitration: pick a master from IDLE, hold the grant until its cyc drops,
  // then hand priority to the other master and switch directly if it waits.
  always_comb begin
    state_d   = state_q;
    prio_d    = prio_q;
    grant_end = 1'b0;
    case (state_q)
      IDLE: begin
        if (m0_cyc_i && m1_cyc_i) begin
          state_d = prio_q ? GNT1 : GNT0;
        end else if (m0_cyc_i) begin
          state_d = GNT0;
        end else if (m1_cyc_i) begin
          state_d = GNT1;
        end
      end
      GNT0: begin
        if (!m0_cyc_i) begin
          grant_end = 1'b1;
          prio_d    = 1'b1;
          state_d   = m1_cyc_i ? GNT1 : IDLE;
        end
      end
      GNT1: begin
        if (!m1_cyc_i) begin
          grant_end = 1'b1;
          prio_d    = 1'b0;
          state_d   = m0_cyc_i ? GNT0 : IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Grant state and round-robin pointer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      prio_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
    end
  end

  // Watchdog: count unanswered strobe cycles and schedule one forced-error
  // cycle once the slave has been silent for TIMEOUT strobe cycles.
  always_ff @(posedge clk) begin
    if (rst || (TIMEOUT == 0)) begin
      wd_cnt_q <= '0;
      forced_q <= 1'b0;
    end else if (forced_q || grant_end || !s_stb_o || slave_term) begin
      wd_cnt_q <= '0;
      forced_q <= 1'b0;
    end else if (wd_cnt_q == CNT_LAST) begin
      wd_cnt_q <= '0;
      forced_q <= 1'b1;
    end else begin
      wd_cnt_q <= wd_cnt_q + CNT_W'(1);
    end
  end

  // Bus mux: the granted master drives the slave and alone sees terminations;
  // a forced-error cycle hides the strobe and replaces any slave response.
  always_comb begin
    s_adr_o  = '0;
    s_dat_o  = '0;
    s_we_o   = 1'b0;
    s_sel_o  = '0;
    s_stb_o  = 1'b0;
    s_cyc_o  = 1'b0;
    m0_ack_o = 1'b0;
    m0_err_o = 1'b0;
    m0_rty_o = 1'b0;
    m1_ack_o = 1'b0;
    m1_err_o = 1'b0;
    m1_rty_o = 1'b0;
    case (state_q)
      GNT0: begin
        s_adr_o  = m0_adr_i;
        s_dat_o  = m0_dat_i;
        s_we_o   = m0_we_i;
        s_sel_o  = m0_sel_i;
        s_stb_o  = m0_stb_i & ~forced_q;
        s_cyc_o  = m0_cyc_i;
        m0_ack_o = s_ack_i & ~forced_q;
        m0_err_o = s_err_i | forced_q;
        m0_rty_o = s_rty_i & ~forced_q;
      end
      GNT1: begin
        s_adr_o  = m1_adr_i;
        s_dat_o  = m1_dat_i;
        s_we_o   = m1_we_i;
        s_sel_o  = m1_sel_i;
        s_stb_o  = m1_stb_i & ~forced_q;
        s_cyc_o  = m1_cyc_i;
        m1_ack_o = s_ack_i & ~forced_q;
        m1_err_o = s_err_i | forced_q;
        m1_rty_o = s_rty_i & ~forced_q;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_wb_arbiter2.sv
// tb_wb_arbiter2: table-driven check of wb_arbiter2 plus hand-written
// sequences for watchdog, mid-transfer reset and disabled-watchdog stall.
module tb_wb_arbiter2;

  localparam int AW = 32;
  localparam int DW = 128;
  localparam int SW = 16;

  localparam logic [AW-1:0] M0_ADR  = 32'h0000_0010;
  localparam logic [AW-1:0] M1_ADR  = 32'h0000_0020;
  localparam logic [DW-1:0] M0_WDAT = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
  localparam logic [DW-1:0] M1_WDAT = 128'h9999_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF_0000;
  localparam logic [DW-1:0] RD_DAT  = 128'h0123_4567_89AB_CDEF_0F1E_2D3C_DEAD_BEEF;
  localparam logic [SW-1:0] M0_SEL  = 16'h00FF;
  localparam logic [SW-1:0] M1_SEL  = 16'hFF00;

  logic clk;
  logic rst;

  logic [AW-1:0] m0_adr, m1_adr;
  logic [DW-1:0] m0_wdat, m1_wdat;
  logic          m0_we, m1_we;
  logic [SW-1:0] m0_sel, m1_sel;
  logic          m0_stb, m0_cyc, m1_stb, m1_cyc;
  logic [DW-1:0] s_rdat;
  logic          s_ack, s_err, s_rty;

  logic [DW-1:0] m0_rdat, m1_rdat;
  logic          m0_ack, m0_err, m0_rty, m1_ack, m1_err, m1_rty;
  logic [AW-1:0] s_adr;
  logic [DW-1:0] s_wdat;
  logic          s_we, s_stb, s_cyc;
  logic [SW-1:0] s_sel;

  logic [DW-1:0] nw_m0_rdat, nw_m1_rdat;
  logic          nw_m0_ack, nw_m0_err, nw_m0_rty, nw_m1_ack, nw_m1_err, nw_m1_rty;
  logic [AW-1:0] nw_s_adr;
  logic [DW-1:0] nw_s_wdat;
  logic          nw_s_we, nw_s_stb, nw_s_cyc;
  logic [SW-1:0] nw_s_sel;

  wb_arbiter2 #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SEL_GRAN(8), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .m0_adr_i(m0_adr), .m0_dat_i(m0_wdat), .m0_dat_o(m0_rdat), .m0_we_i(m0_we),
    .m0_sel_i(m0_sel), .m0_stb_i(m0_stb), .m0_cyc_i(m0_cyc),
    .m0_ack_o(m0_ack), .m0_err_o(m0_err), .m0_rty_o(m0_rty),
    .m1_adr_i(m1_adr), .m1_dat_i(m1_wdat), .m1_dat_o(m1_rdat), .m1_we_i(m1_we),
    .m1_sel_i(m1_sel), .m1_stb_i(m1_stb), .m1_cyc_i(m1_cyc),
    .m1_ack_o(m1_ack), .m1_err_o(m1_err), .m1_rty_o(m1_rty),
    .s_adr_o(s_adr), .s_dat_o(s_wdat), .s_dat_i(s_rdat), .s_we_o(s_we),
    .s_sel_o(s_sel), .s_stb_o(s_stb), .s_cyc_o(s_cyc),
    .s_ack_i(s_ack), .s_err_i(s_err), .s_rty_i(s_rty)
  );

  wb_arbiter2 #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SEL_GRAN(8), .TIMEOUT(0)) dut_nowd (
    .clk(clk), .rst(rst),
    .m0_adr_i(m0_adr), .m0_dat_i(m0_wdat), .m0_dat_o(nw_m0_rdat), .m0_we_i(m0_we),
    .m0_sel_i(m0_sel), .m0_stb_i(m0_stb), .m0_cyc_i(m0_cyc),
    .m0_ack_o(nw_m0_ack), .m0_err_o(nw_m0_err), .m0_rty_o(nw_m0_rty),
    .m1_adr_i(m1_adr), .m1_dat_i(m1_wdat), .m1_dat_o(nw_m1_rdat), .m1_we_i(m1_we),
    .m1_sel_i(m1_sel), .m1_stb_i(m1_stb), .m1_cyc_i(m1_cyc),
    .m1_ack_o(nw_m1_ack), .m1_err_o(nw_m1_err), .m1_rty_o(nw_m1_rty),
    .s_adr_o(nw_s_adr), .s_dat_o(nw_s_wdat), .s_dat_i(s_rdat), .s_we_o(nw_s_we),
    .s_sel_o(nw_s_sel), .s_stb_o(nw_s_stb), .s_cyc_o(nw_s_cyc),
    .s_ack_i(s_ack), .s_err_i(s_err), .s_rty_i(s_rty)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // in_bits = {rst, m0_cyc, m0_stb, m1_cyc, m1_stb, s_ack, s_err, s_rty}
  // gnt: 0 none, 1 master 0, 2 master 1
  // term = {m0_ack, m0_err, m0_rty, m1_ack, m1_err, m1_rty}
  typedef struct {
    string      name;
    logic [7:0] in_bits;
    logic [1:0] gnt;
    logic       cyc;
    logic       stb;
    logic [5:0] term;
  } vec_t;

  vec_t vecs[$];
  int   total = 0;
  int   bad   = 0;

  task automatic addVec(input string name, input logic [7:0] in_bits, input logic [1:0] gnt,
                        input logic cyc, input logic stb, input logic [5:0] term);
    vec_t v;
    v.name    = name;
    v.in_bits = in_bits;
    v.gnt     = gnt;
    v.cyc     = cyc;
    v.stb     = stb;
    v.term    = term;
    vecs.push_back(v);
  endtask

  task automatic compareField(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input vec_t v);
    tick();
    {rst, m0_cyc, m0_stb, m1_cyc, m1_stb, s_ack, s_err, s_rty} = v.in_bits;
  endtask

  task automatic checkOutput(input vec_t v);
    logic [AW-1:0] eadr;
    logic [DW-1:0] edat;
    logic [SW:0]   ewesel;
    @(negedge clk);
    case (v.gnt)
      2'd1:    begin eadr = M0_ADR; edat = M0_WDAT; ewesel = {1'b0, M0_SEL}; end
      2'd2:    begin eadr = M1_ADR; edat = M1_WDAT; ewesel = {1'b1, M1_SEL}; end
      default: begin eadr = '0;     edat = '0;      ewesel = '0;             end
    endcase
    compareField({v.name, ".s_adr"},  DW'(s_adr), DW'(eadr));
    compareField({v.name, ".s_dat"},  s_wdat, edat);
    compareField({v.name, ".s_wesel"}, DW'({s_we, s_sel}), DW'(ewesel));
    compareField({v.name, ".s_cyc"},  DW'(s_cyc), DW'(v.cyc));
    compareField({v.name, ".s_stb"},  DW'(s_stb), DW'(v.stb));
    compareField({v.name, ".term"},
                 DW'({m0_ack, m0_err, m0_rty, m1_ack, m1_err, m1_rty}), DW'(v.term));
    compareField({v.name, ".m0_dat"}, m0_rdat, RD_DAT);
    compareField({v.name, ".m1_dat"}, m1_rdat, RD_DAT);
  endtask

  // Hard stop in case the run ever stalls.
  initial begin
    #100000;
    $display("[TB] FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int  errs;
    int  stb_low;
    logic fire;

    rst     = 1'b1;
    m0_adr  = M0_ADR;  m1_adr  = M1_ADR;
    m0_wdat = M0_WDAT; m1_wdat = M1_WDAT;
    m0_we   = 1'b0;    m1_we   = 1'b1;
    m0_sel  = M0_SEL;  m1_sel  = M1_SEL;
    m0_stb  = 1'b0; m0_cyc = 1'b0; m1_stb = 1'b0; m1_cyc = 1'b0;
    s_rdat  = RD_DAT;
    s_ack   = 1'b0; s_err = 1'b0; s_rty = 1'b0;

    // m0 single read
    addVec("reset_idle",     8'b0_00_00_000, 2'd0, 1'b0, 1'b0, 6'b000_000);
    addVec("m0_req",         8'b0_11_00_000, 2'd0, 1'b0, 1'b0, 6'b000_000);
    addVec("m0_wait",        8'b0_11_00_000, 2'd1, 1'b1, 1'b1, 6'b000_000);
    addVec("m0_ack",         8'b0_11_00_100, 2'd1, 1'b1, 1'b1, 6'b100_000);
    addVec("m0_release",     8'b0_00_00_000, 2'd1, 1'b0, 1'b0, 6'b000_000);
    addVec("idle1",          8'b0_00_00_000, 2'd0, 1'b0, 1'b0, 6'b000_000);
    // tie after reset, back-to-back handover, next tie
    addVec("rst_pulse",      8'b1_00_00_000, 2'd0, 1'b0, 1'b0, 6'b000_000);
    addVec("tie_req",        8'b0_11_11_000, 2'd0, 1'b0, 1'b0, 6'b000_000);
    addVec("tie_gnt0",       8'b0_11_11_000, 2'd1, 1'b1, 1'b1, 6'b000_000);
    addVec("tie_m0_ack",     8'b0_11_11_100, 2'd1, 1'b1, 1'b1, 6'b100_000);
    addVec("m0_drop",        8'b0_00_11_000, 2'd1, 1'b0, 1'b0, 6'b000_000);
    addVec("m1_direct",      8'b0_00_11_100, 2'd2, 1'b1, 1'b1, 6'b000_100);
    addVec("m1_drop",        8'b0_00_00_000, 2'd2, 1'b0, 1'b0, 6'b000_000);
    addVec("tie2_req",       8'b0_11_11_000, 2'd0, 1'b0, 1'b0, 6'b000_000);
    addVec("tie2_gnt0",      8'b0_11_11_000, 2'd1, 1'b1, 1'b1, 6'b000_000);
    addVec("m0_drop2",       8'b0_00_11_000, 2'd1, 1'b0, 1'b0, 6'b000_000);
    // m1 burst with a strobe gap while m0 keeps requesting
    addVec("burst_b1",       8'b0_11_11_100, 2'd2, 1'b1, 1'b1, 6'b000_100);
    addVec("burst_gap",      8'b0_11_10_000, 2'd2, 1'b1, 1'b0, 6'b000_000);
    addVec("burst_b2",       8'b0_11_11_100, 2'd2, 1'b1, 1'b1, 6'b000_100);
    addVec("burst_b3",       8'b0_11_11_100, 2'd2, 1'b1, 1'b1, 6'b000_100);
    addVec("burst_b4_ackerr",8'b0_11_11_110, 2'd2, 1'b1, 1'b1, 6'b000_110);
    addVec("burst_end_ack",  8'b0_11_00_100, 2'd2, 1'b0, 1'b0, 6'b000_100);
    addVec("m0_rty",         8'b0_11_00_001, 2'd1, 1'b1, 1'b1, 6'b001_000);
    addVec("m0_release3",    8'b0_00_00_000, 2'd1, 1'b0, 1'b0, 6'b000_000);
    addVec("idle2",          8'b0_00_00_000, 2'd0, 1'b0, 1'b0, 6'b000_000);

    repeat (3) @(posedge clk);
    $display("[TB] applying %0d table vectors", vecs.size());
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      checkOutput(vecs[i]);
    end

    // Watchdog (TIMEOUT=8): silent slave, forced error every ninth cycle.
    tick(); m0_cyc = 1'b1; m0_stb = 1'b1;
    for (int i = 0; i < 18; i++) begin
      tick(); s_ack = (i == 8);
      @(negedge clk);
      fire = (i == 8) || (i == 17);
      compareField($sformatf("wd[%0d].m0_err", i), DW'(m0_err), DW'(fire));
      compareField($sformatf("wd[%0d].s_stb", i),  DW'(s_stb),  DW'(!fire));
      compareField($sformatf("wd[%0d].m0_ack", i), DW'(m0_ack), DW'(1'b0));
    end
    tick(); s_ack = 1'b0; m0_cyc = 1'b0; m0_stb = 1'b0;
    tick();

    // Reset while m1 waits for an ack; afterwards a tie must go to m0.
    tick(); m1_cyc = 1'b1; m1_stb = 1'b1;
    tick();
    @(negedge clk);
    compareField("rst.pre_cyc", DW'(s_cyc), DW'(1'b1));
    compareField("rst.pre_adr", DW'(s_adr), DW'(M1_ADR));
    tick(); rst = 1'b1;
    tick(); rst = 1'b0; m0_cyc = 1'b1; m0_stb = 1'b1;
    @(negedge clk);
    compareField("rst.post_cyc", DW'(s_cyc), DW'(1'b0));
    compareField("rst.post_stb", DW'(s_stb), DW'(1'b0));
    compareField("rst.post_adr", DW'(s_adr), DW'(0));
    tick();
    @(negedge clk);
    compareField("rst.tie_adr", DW'(s_adr), DW'(M0_ADR));
    compareField("rst.tie_cyc", DW'(s_cyc), DW'(1'b1));
    compareField("rst.tie_we",  DW'(s_we),  DW'(1'b0));
    tick(); m0_cyc = 1'b0; m0_stb = 1'b0; m1_cyc = 1'b0; m1_stb = 1'b0;
    tick();

    // Watchdog disabled (TIMEOUT=0): 200-cycle stall, then ack is delivered.
    tick(); m0_cyc = 1'b1; m0_stb = 1'b1;
    errs    = 0;
    stb_low = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      @(negedge clk);
      if (nw_m0_err !== 1'b0) errs++;
      if (nw_s_stb !== 1'b1) stb_low++;
    end
    compareField("stall.err_cycles", DW'(errs), DW'(0));
    compareField("stall.stb_low_cycles", DW'(stb_low), DW'(0));
    tick(); s_ack = 1'b1;
    @(negedge clk);
    compareField("stall.m0_ack", DW'(nw_m0_ack), DW'(1'b1));
    compareField("stall.m0_err", DW'(nw_m0_err), DW'(1'b0));
    compareField("stall.m1_ack", DW'(nw_m1_ack), DW'(1'b0));
    compareField("stall.m0_dat", nw_m0_rdat, RD_DAT);
    tick(); s_ack = 1'b0; m0_cyc = 1'b0; m0_stb = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_arbiter2.md
Name: wb_arbiter2

Overview:
- Two-master to one-slave Wishbone classic arbiter, 128-bit data path, placed between the CPU's instruction-fetch and data-access bus masters and the shared `wb_ram`.
- Grants the slave to one master per bus cycle (`cyc`-delimited) using round-robin priority.
- Routes termination signals back only to the granted master.
- Guards against a hung slave with a watchdog that converts a stalled strobe into an error termination.

Parameters:
- ADDR_WIDTH, 32, address width of master and slave ports.
- DATA_WIDTH, 128, data width; must be a multiple of SEL_GRAN.
- SEL_GRAN, 8, bits per select line; SEL_WIDTH = DATA_WIDTH/SEL_GRAN (16 by default).
- TIMEOUT, 64, watchdog cycles before forced error; 0 disables the watchdog.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- mN_adr_i  in  ADDR_WIDTH  master N address (N = 0, 1; all mN_ ports exist for both masters).
- mN_dat_i  in  DATA_WIDTH  master N write data.
- mN_dat_o  out  DATA_WIDTH  read data to master N.
- mN_we_i  in  1  master N write enable.
- mN_sel_i  in  SEL_WIDTH  master N byte selects.
- mN_stb_i  in  1  master N strobe.
- mN_cyc_i  in  1  master N cycle request.
- mN_ack_o  out  1  ack to master N.
- mN_err_o  out  1  error to master N.
- mN_rty_o  out  1  retry to master N.
- s_adr_o  out  ADDR_WIDTH  slave address.
- s_dat_o  out  DATA_WIDTH  slave write data.
- s_dat_i  in  DATA_WIDTH  slave read data.
- s_we_o  out  1  slave write enable.
- s_sel_o  out  SEL_WIDTH  slave byte selects.
- s_stb_o  out  1  slave strobe.
- s_cyc_o  out  1  slave cycle.
- s_ack_i  in  1  slave ack.
- s_err_i  in  1  slave error.
- s_rty_i  in  1  slave retry.

Behaviour:
- State register: IDLE, GNT0, GNT1. Priority pointer `prio` (0 or 1) names the master that wins a tie.
- Reset: state = IDLE, `prio` = 0, watchdog count = 0.
- Output muxing is combinational from the registered state:
  - In IDLE, every s_* output and every m*_ack/err/rty output is 0.
  - mN_dat_o = s_dat_i for both masters at all times; data is qualified only by ack.
- IDLE transitions:
  - Only m0_cyc_i high -> GNT0.
  - Only m1_cyc_i high -> GNT1.
  - Both high -> GNT`prio`.
  - Neither -> stay in IDLE.
  - Arbitration latency is 1 cycle: `cyc` asserted at edge k reaches s_cyc_o after edge k+1.
- GNTn:
  - s_adr/dat/we/sel/stb/cyc = mN inputs.
  - mN_ack/err/rty = s_ack/err/rty; the other master sees 0 on all three.
  - Grant is held while mN_cyc_i = 1, across any number of beats and across stb gaps, regardless of requests from the other master.
- End of grant: when mN_cyc_i = 0 in GNTn:
  - `prio` <= other master.
  - If the other master's `cyc` = 1, go directly to GNTother (no bubble); else go to IDLE.
  - s_cyc_o drops in the same cycle that mN_cyc_i drops, since it is combinational.
- Watchdog (TIMEOUT > 0):
  - Count increments each cycle with s_stb_o = 1 and s_ack_i | s_err_i | s_rty_i = 0.
  - Count clears on any slave termination, on s_stb_o = 0, or on a grant change.
  - When count = TIMEOUT-1 and there is still no termination, the next cycle is a forced-error cycle:
    - mN_err_o = 1 and mN_ack_o = 0.
    - s_stb_o = 0.
    - Count clears.
  - Any slave ack/err/rty arriving during the forced-error cycle is dropped.
- Simultaneous events:
  - Slave asserting ack and err together: both are passed through unchanged; no arbitration between them.
  - Master dropping `cyc` in the same cycle as a slave ack: the ack is delivered, and the grant ends at that edge.
- Reset mid-transfer: at the reset edge, state goes to IDLE and s_cyc_o/s_stb_o go to 0 the next cycle; an in-flight slave ack is ignored.
- `prio` changes only at end of grant.

Test Plan:
- Reset, then m0 single read (adr 0x10, stb = cyc = 1), slave acks with dat 0x…DEADBEEF one cycle later -> s_cyc_o high 1 cycle after request; m0_ack_o = 1 with m0_dat_o = 0x…DEADBEEF; m1_ack_o stays 0.
- m0 and m1 raise `cyc` in the same cycle right after reset -> m0 granted first; on m0 `cyc` drop, m1 is granted on the very next edge with no IDLE cycle; the following tie goes to m0.
- m1 holds `cyc` for a 4-beat burst with stb low on beat 2 while m0 requests throughout -> grant stays GNT1 until m1 `cyc` = 0; m0 sees no ack/err/rty during the burst.
- TIMEOUT = 8, slave never responds to m0 strobe -> after 8 strobe cycles, m0_err_o pulses for 1 cycle with s_stb_o = 0; the next strobe restarts the count from 0.
- Assert rst during a GNT1 cycle awaiting ack -> s_cyc_o = s_stb_o = 0 the next cycle; state IDLE; a subsequent tie grants m0.
- TIMEOUT = 0, slave stalls 200 cycles then acks -> no err is generated; the ack is delivered to the granted master.
